// File: rtl/led_pkg.sv
// Shared definitions for the LED matrix display blocks.
// Holds matrix geometry constants, the scan/display-mode enums, the frame
// snapshot record and the row-to-column mapping helper.
package led_pkg;

    localparam int unsigned ROWS          = 8;
    localparam int unsigned COLS          = 8;
    localparam int unsigned SLOTS         = 10;
    localparam int unsigned SCROLL_THRESH = 4;

    typedef enum logic {
        StBlank = 1'b0,
        StOn    = 1'b1
    } scan_state_t;

    typedef enum logic [1:0] {
        ModeNormal = 2'd0,
        ModeFlash  = 2'd1,
        ModeDone   = 2'd2
    } disp_mode_t;

    // Frame-coherent copy of the upstream note stage outputs.
    typedef struct packed {
        logic [SLOTS-1:0] r;
        logic [SLOTS-1:0] b;
        logic [2:0]       offset;
    } snapshot_t;

    // Returns {col_R, col_B} for one row. Red notes light the low half of the
    // red drive, blue notes the high half of the blue drive. A scroll phase
    // past the threshold shifts the display by one slot, so slot 9 is never
    // reachable.
    function automatic logic [15:0] row_columns(snapshot_t snap, logic [2:0] row,
                                                disp_mode_t mode);
        logic [3:0]  slot;
        logic [15:0] cols;
        slot = {1'b0, row} + ((snap.offset >= 3'(SCROLL_THRESH)) ? 4'd1 : 4'd0);
        cols = '0;
        case (mode)
            ModeNormal: cols = {4'h0, {4{snap.r[slot]}}, {4{snap.b[slot]}}, 4'h0};
            ModeFlash:  cols = {8'hFF, 8'h00};
            default:    cols = '0;
        endcase
        return cols;
    endfunction

endpackage

// File: rtl/row_scan_counter.sv
// Row scan sequencer for the LED matrix.
// Alternates a BLANK gap and an ON dwell for each of the 8 rows.
// Ports:
//   clk, rst          - clock, synchronous active-high reset
//   state_nxt_o       - scan state for the next cycle (1 = ON)
//   row_idx_nxt_o     - row index for the next cycle
//   frame_boundary_o  - high in the cycle the scan sits at BLANK, cnt 0, row 0
module row_scan_counter import led_pkg::*; #(
    parameter int unsigned DWELL = 1000,
    parameter int unsigned BLANK = 16
) (
    input  logic       clk,
    input  logic       rst,
    output logic       state_nxt_o,
    output logic [2:0] row_idx_nxt_o,
    output logic       frame_boundary_o
);

    localparam logic [15:0] DwellLast = 16'(DWELL - 1);
    localparam logic [15:0] BlankLast = 16'(BLANK - 1);

    scan_state_t state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [2:0]  row_q, row_d;
    logic        start_q;
    logic        fb_q, fb_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 16'd1;
        row_d   = row_q;
        if (start_q) begin
            // First cycle out of reset re-enters BLANK/row 0 so that it is
            // reported as a frame boundary.
            state_d = StBlank;
            cnt_d   = '0;
            row_d   = '0;
        end else if (state_q == StBlank) begin
            if (cnt_q == BlankLast) begin
                state_d = StOn;
                cnt_d   = '0;
            end
        end else if (cnt_q == DwellLast) begin
            state_d = StBlank;
            cnt_d   = '0;
            row_d   = row_q + 3'd1;
        end
        fb_d = (state_d == StBlank) && (cnt_d == '0) && (row_d == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StBlank;
            cnt_q   <= '0;
            row_q   <= '0;
            start_q <= 1'b1;
            fb_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            row_q   <= row_d;
            start_q <= 1'b0;
            fb_q    <= fb_d;
        end
    end

    assign state_nxt_o      = state_d;
    assign row_idx_nxt_o    = row_d;
    assign frame_boundary_o = fb_q;

endmodule

// File: rtl/led_matrix_scan.sv
// Display back-end: scans the note vectors onto an 8x8 common-row RGB matrix.
// A snapshot of the inputs is latched at every frame boundary so a frame is
// never torn; a song-end pulse triggers a full-red flash sequence.
// Ports:
//   clk, rst           - clock, synchronous active-high reset
//   note_R, note_B     - per-slot red/blue notes (slot 0 nearest)
//   offset             - scroll phase, >= 4 shifts display by one slot
//   finish             - one-cycle song-end pulse
//   row_n              - active-low one-hot row select, FF = all off
//   col_R, col_B       - active-high column drives
//   frame_sync         - one-cycle pulse at each snapshot latch
module led_matrix_scan import led_pkg::*; #(
    parameter int unsigned DWELL        = 1000,
    parameter int unsigned BLANK        = 16,
    parameter int unsigned FLASH_FRAMES = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] note_R,
    input  logic [9:0] note_B,
    input  logic [2:0] offset,
    input  logic       finish,
    output logic [7:0] row_n,
    output logic [7:0] col_R,
    output logic [7:0] col_B,
    output logic       frame_sync
);

    localparam logic [7:0] FlashLoad = 8'(FLASH_FRAMES);

    logic       state_nxt;
    logic [2:0] row_nxt;
    logic       boundary;

    row_scan_counter #(
        .DWELL (DWELL),
        .BLANK (BLANK)
    ) u_row_scan_counter (
        .clk              (clk),
        .rst              (rst),
        .state_nxt_o      (state_nxt),
        .row_idx_nxt_o    (row_nxt),
        .frame_boundary_o (boundary)
    );

    snapshot_t  snap_q, snap_d;
    disp_mode_t mode_q, mode_d;
    logic [7:0] flash_q, flash_d;
    logic       pend_q, pend_d;
    logic [7:0] row_n_q, row_n_d;
    logic [7:0] col_r_q, col_r_d;
    logic [7:0] col_b_q, col_b_d;
    logic [15:0] cols;

    always_comb begin
        snap_d  = snap_q;
        mode_d  = mode_q;
        flash_d = flash_q;
        pend_d  = pend_q | finish;
        if (boundary) begin
            snap_d = '{r: note_R, b: note_B, offset: offset};
            pend_d = 1'b0;
            if (finish || pend_q) begin
                // A pending or same-cycle finish (re)starts the flash.
                mode_d  = ModeFlash;
                flash_d = FlashLoad;
            end else begin
                case (mode_q)
                    ModeFlash: begin
                        if (flash_q <= 8'd1) begin
                            mode_d = ModeDone;
                        end
                        flash_d = flash_q - 8'd1;
                    end
                    ModeDone: begin
                        if (|(note_R | note_B)) begin
                            mode_d = ModeNormal;
                        end
                    end
                    default: ;
                endcase
            end
        end

        // Columns use the post-boundary snapshot/mode so a new frame shows
        // its own data even when BLANK is a single cycle.
        cols = row_columns(snap_d, row_nxt, mode_d);
        if (state_nxt == StOn) begin
            row_n_d = ~(8'd1 << row_nxt);
            col_r_d = cols[15:8];
            col_b_d = cols[7:0];
        end else begin
            row_n_d = 8'hFF;
            col_r_d = 8'h00;
            col_b_d = 8'h00;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            snap_q  <= '0;
            mode_q  <= ModeNormal;
            flash_q <= '0;
            pend_q  <= 1'b0;
            row_n_q <= 8'hFF;
            col_r_q <= 8'h00;
            col_b_q <= 8'h00;
        end else begin
            snap_q  <= snap_d;
            mode_q  <= mode_d;
            flash_q <= flash_d;
            pend_q  <= pend_d;
            row_n_q <= row_n_d;
            col_r_q <= col_r_d;
            col_b_q <= col_b_d;
        end
    end

    assign row_n      = row_n_q;
    assign col_R      = col_r_q;
    assign col_B      = col_b_q;
    assign frame_sync = boundary;

endmodule
